// File: rtl/glitc_intercom_tx_framer.sv
// GLITC intercom transmit framer: TRAIN -> SYNC -> DATA word sequencer feeding 4 OSERDES lanes.
// Optional PRBS test-pattern source compiled in with `define GLITC_INTERCOM_TX_PRBS_EN.
module glitc_intercom_tx_framer #(
   parameter int unsigned TRAIN_CYCLES = 64,
   parameter logic [15:0] TRAIN_WORD   = 16'h1111,
   parameter logic [15:0] SYNC_WORD    = 16'hF0F0,
   parameter logic [15:0] IDLE_WORD    = 16'h0000
) (
   input  logic        sysclk_i,
   input  logic        rst_i,
   input  logic        train_i,
   input  logic [15:0] data_i,
   input  logic        valid_i,
`ifdef GLITC_INTERCOM_TX_PRBS_EN
   input  logic        prbs_i,
`endif
   output logic        ready_o,
   output logic [15:0] d_o,
   output logic        trained_o,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      ST_TRAIN = 2'd0,
      ST_SYNC  = 2'd1,
      ST_DATA  = 2'd2,
      ST_BAD   = 2'd3
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(TRAIN_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] d_q, d_d;
   logic        trained_q, trained_d;
   logic        prbs_sel;

`ifdef GLITC_INTERCOM_TX_PRBS_EN
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   logic [15:0] lfsr_q, lfsr_d, lfsr_next;

   always_comb begin
      lfsr_next = {1'b0, lfsr_q[15:1]};
      if (lfsr_q[0]) lfsr_next = lfsr_next ^ LFSR_TAPS;
   end
   assign prbs_sel = prbs_i;
`else
   assign prbs_sel = 1'b0;
`endif

   // Handshake is combinational so a word can be accepted in the same cycle it is offered.
   assign ready_o = (state_q == ST_DATA) && !train_i && !prbs_sel && !rst_i;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves a latch behind.
      state_d   = state_q;
      cnt_d     = cnt_q;
      d_d       = d_q;
      trained_d = 1'b0;
`ifdef GLITC_INTERCOM_TX_PRBS_EN
      lfsr_d    = lfsr_q;
`endif
      case (state_q)
         ST_TRAIN: begin
            d_d = TRAIN_WORD;
            if (train_i) begin
               cnt_d = CNT_LOAD;
            end else if (cnt_q == 8'd0) begin
               state_d = ST_SYNC;
               d_d     = SYNC_WORD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_SYNC: begin
            if (train_i) begin
               state_d = ST_TRAIN;
               cnt_d   = CNT_LOAD;
               d_d     = TRAIN_WORD;
            end else begin
               state_d   = ST_DATA;
               d_d       = IDLE_WORD;
               trained_d = 1'b1;
            end
         end
         ST_DATA: begin
            if (train_i) begin
               state_d = ST_TRAIN;
               cnt_d   = CNT_LOAD;
               d_d     = TRAIN_WORD;
            end else begin
               trained_d = 1'b1;
`ifdef GLITC_INTERCOM_TX_PRBS_EN
               if (prbs_i) begin
                  d_d    = lfsr_q;
                  lfsr_d = lfsr_next;
               end else begin
                  d_d = (valid_i && ready_o) ? data_i : IDLE_WORD;
               end
`else
               d_d = (valid_i && ready_o) ? data_i : IDLE_WORD;
`endif
            end
         end
         default: begin
            state_d = ST_TRAIN;
            cnt_d   = CNT_LOAD;
            d_d     = TRAIN_WORD;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sysclk_i) begin
      if (rst_i) begin
         state_q   <= ST_TRAIN;
         cnt_q     <= CNT_LOAD;
         d_q       <= TRAIN_WORD;
         trained_q <= 1'b0;
`ifdef GLITC_INTERCOM_TX_PRBS_EN
         lfsr_q    <= LFSR_SEED;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         d_q       <= d_d;
         trained_q <= trained_d;
`ifdef GLITC_INTERCOM_TX_PRBS_EN
         lfsr_q    <= lfsr_d;
`endif
      end
   end

   assign d_o       = d_q;
   assign trained_o = trained_q;
   assign state_o   = state_q;

endmodule
